// File: rtl/fifo_rd_packer.sv
// Read-side width upsizer: drains a 1-cycle-latency FIFO and packs RATIO words per output beat.
// Optional flush path (partial word + lane keep mask) is built with `define FIFO_RD_PACKER_FLUSH_EN.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  output logic                     o_Rd_En,
  input  logic                     i_Rd_DV,
  input  logic [WIDTH-1:0]         i_Rd_Data,
  input  logic                     i_Empty,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic [WIDTH*RATIO-1:0]   o_Data,
  output logic [RATIO-1:0]         o_Keep,
  input  logic                     i_Flush,
  output logic                     o_Flush_Done
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  typedef enum logic [1:0] {RUN, DRAIN, EMIT} state_t;

  state_t                       state, state_n;
  logic [CW-1:0]                ipos, cnt, cnt_nxt;
  logic [WIDTH*(RATIO-1)-1:0]   acc;
  logic                         out_free, grp_done, emit_load;
  logic [WIDTH*RATIO-1:0]       data_part;

  assign out_free = !o_Valid || i_Ready;
  assign grp_done = i_Rd_DV && (cnt == LAST);

  // Only the group-completing read waits for the output register to free up.
  always_comb begin
    o_Rd_En = i_Rst_L && !i_Empty && (state == RUN) && ((ipos != LAST) || out_free);
  end

  always_comb begin
    cnt_nxt = cnt;
    if (i_Rd_DV) cnt_nxt = grp_done ? '0 : cnt + CW'(1);
  end

`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic             drain_done;
  logic [RATIO-1:0] keep_part, keep_q;
  logic             fd_q;

  // DRAIN lasts one cycle: the only possible in-flight read returns in it, so cnt_nxt is final.
  always_comb begin
    state_n    = state;
    emit_load  = 1'b0;
    drain_done = 1'b0;
    data_part  = '0;
    keep_part  = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++)
      if (CW'(k) < cnt) data_part[k*WIDTH +: WIDTH] = acc[k*WIDTH +: WIDTH];
    for (int unsigned k = 0; k < RATIO; k++)
      keep_part[k] = (CW'(k) < cnt);
    unique case (state)
      RUN:   if (i_Flush) state_n = DRAIN;
      DRAIN: begin
        if (cnt_nxt == '0) begin
          state_n    = RUN;
          drain_done = 1'b1;
        end else begin
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (out_free) begin
          state_n   = RUN;
          emit_load = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      keep_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      fd_q <= drain_done || emit_load;
      if (grp_done)  keep_q <= '1;
      if (emit_load) keep_q <= keep_part;
    end
  end

  assign o_Keep       = keep_q;
  assign o_Flush_Done = fd_q;
`else
  logic flush_unused;

  always_comb begin
    state_n   = RUN;
    emit_load = 1'b0;
    data_part = '0;
  end

  assign flush_unused = i_Flush;
  assign o_Keep       = {RATIO{o_Valid}};
  assign o_Flush_Done = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= RUN;
      ipos    <= '0;
      cnt     <= '0;
      acc     <= '0;
      o_Valid <= 1'b0;
      o_Data  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_nxt;
      if (o_Rd_En) ipos <= (ipos == LAST) ? '0 : ipos + CW'(1);
      for (int unsigned k = 0; k < RATIO - 1; k++)
        if (i_Rd_DV && (cnt == CW'(k))) acc[k*WIDTH +: WIDTH] <= i_Rd_Data;
      if (o_Valid && i_Ready) o_Valid <= 1'b0;
      if (grp_done) begin
        o_Data  <= {i_Rd_Data, acc};
        o_Valid <= 1'b1;
      end
      if (emit_load) begin
        o_Data  <= data_part;
        o_Valid <= 1'b1;
        cnt     <= '0;
        ipos    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (WIDTH=8, RATIO=4) fed by a 16-deep non-FWFT FIFO model.
module tb_fifo_rd_packer;
  localparam int WIDTH = 8;
  localparam int RATIO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en, rd_dv, empty, valid, ready, flush, flush_done;
  logic [7:0]  rd_data;
  logic [31:0] data;
  logic [3:0]  keep;
  logic        wr;
  logic [7:0]  wd;

  logic [7:0]  fmem [16];
  logic [3:0]  wp, rp;
  logic [4:0]  fcount;
  logic        rd_ok;

  int n_pass = 0, n_total = 0;
  int cyc = 0, rd_cnt = 0, run_len = 0, last_run = 0, last_rd_cyc = 0;
  int rd_empty_cnt = 0, valid_cnt = 0, acc_n = 0, flush_cyc = 0, fd_cnt = 0, fd_cyc = 0;
  logic [31:0] acc_data [64];
  logic [3:0]  acc_keep [64];
  logic        acc_fd   [64];
  int          acc_cyc  [64];

  always #5 clk = ~clk;

  fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .o_Rd_En(rd_en), .i_Rd_DV(rd_dv), .i_Rd_Data(rd_data),
    .i_Empty(empty), .o_Valid(valid), .i_Ready(ready), .o_Data(data), .o_Keep(keep),
    .i_Flush(flush), .o_Flush_Done(flush_done)
  );

  assign empty = (fcount == 5'd0);
  assign rd_ok = rd_en && !empty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; fcount <= '0; rd_dv <= 1'b0; rd_data <= '0;
    end else begin
      rd_dv <= rd_ok;
      if (rd_ok) begin
        rd_data <= fmem[rp];
        rp <= rp + 4'd1;
      end
      if (wr) begin
        fmem[wp] <= wd;
        wp <= wp + 4'd1;
      end
      fcount <= fcount + 5'(wr) - 5'(rd_ok);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      cyc <= cyc + 1;
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1;
        run_len <= run_len + 1;
        last_rd_cyc <= cyc;
        if (empty) rd_empty_cnt <= rd_empty_cnt + 1;
      end else if (run_len > 0) begin
        last_run <= run_len;
        run_len <= 0;
      end
      if (valid) valid_cnt <= valid_cnt + 1;
      if (valid && ready && acc_n < 64) begin
        acc_data[acc_n] <= data;
        acc_keep[acc_n] <= keep;
        acc_fd[acc_n]   <= flush_done;
        acc_cyc[acc_n]  <= cyc;
        acc_n <= acc_n + 1;
      end
      if (flush) flush_cyc <= cyc;
      if (flush_done) begin
        fd_cnt <= fd_cnt + 1;
        fd_cyc <= cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_words(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1;
      wd = first + 8'(i);
      tick(1);
    end
    wr = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else n_pass++;
    n_total++; if (data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", data); else n_pass++;
    n_total++; if (keep !== 4'h0) $display("FAIL reset_keep: got %h expected 0", keep); else n_pass++;
    n_total++; if (flush_done !== 1'b0) $display("FAIL reset_flush_done: got %b expected 0", flush_done); else n_pass++;
    n_total++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", rd_en); else n_pass++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic;
    int r0, a0, v0;
    ready = 1'b1;
    r0 = rd_cnt; a0 = acc_n; v0 = valid_cnt;
    write_words(8'h01, 4);
    tick(6);
    n_total++; if (rd_cnt - r0 !== 4) $display("FAIL basic_reads: got %0d expected 4", rd_cnt - r0); else n_pass++;
    n_total++; if (last_run !== 4) $display("FAIL basic_consecutive: got %0d expected 4", last_run); else n_pass++;
    n_total++; if (acc_n - a0 !== 1) $display("FAIL basic_words: got %0d expected 1", acc_n - a0); else n_pass++;
    n_total++; if (acc_data[a0] !== 32'h04030201) $display("FAIL basic_data: got %h expected 04030201", acc_data[a0]); else n_pass++;
    n_total++; if (acc_keep[a0] !== 4'hF) $display("FAIL basic_keep: got %h expected f", acc_keep[a0]); else n_pass++;
    n_total++; if (acc_cyc[a0] - last_rd_cyc !== 2) $display("FAIL basic_latency: got %0d expected 2", acc_cyc[a0] - last_rd_cyc); else n_pass++;
    n_total++; if (valid_cnt - v0 !== 1) $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cnt - v0); else n_pass++;
  endtask

  task automatic test_backpressure;
    int r0, a0;
    ready = 1'b0;
    r0 = rd_cnt; a0 = acc_n;
    write_words(8'h10, 8);
    tick(8);
    n_total++; if (rd_cnt - r0 !== 7) $display("FAIL bp_reads_stalled: got %0d expected 7", rd_cnt - r0); else n_pass++;
    n_total++; if (valid !== 1'b1) $display("FAIL bp_valid: got %b expected 1", valid); else n_pass++;
    n_total++; if (data !== 32'h13121110) $display("FAIL bp_data: got %h expected 13121110", data); else n_pass++;
    n_total++; if (keep !== 4'hF) $display("FAIL bp_keep: got %h expected f", keep); else n_pass++;
    n_total++; if (rd_en !== 1'b0) $display("FAIL bp_rd_en: got %b expected 0", rd_en); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL bp_fifo_nonempty: got %b expected 0", empty); else n_pass++;
    tick(4);
    n_total++; if (data !== 32'h13121110) $display("FAIL bp_data_hold: got %h expected 13121110", data); else n_pass++;
    n_total++; if (rd_cnt - r0 !== 7) $display("FAIL bp_reads_hold: got %0d expected 7", rd_cnt - r0); else n_pass++;
    ready = 1'b1;
    tick(8);
    n_total++; if (acc_n - a0 !== 2) $display("FAIL bp_words: got %0d expected 2", acc_n - a0); else n_pass++;
    n_total++; if (acc_data[a0] !== 32'h13121110) $display("FAIL bp_word0: got %h expected 13121110", acc_data[a0]); else n_pass++;
    n_total++; if (acc_data[a0+1] !== 32'h17161514) $display("FAIL bp_word1: got %h expected 17161514", acc_data[a0+1]); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL bp_fifo_empty: got %b expected 1", empty); else n_pass++;
    n_total++; if (rd_cnt - r0 !== 8) $display("FAIL bp_reads_total: got %0d expected 8", rd_cnt - r0); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL bp_valid_clear: got %b expected 0", valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int r0, a0, v0;
    ready = 1'b1;
    r0 = rd_cnt; a0 = acc_n; v0 = valid_cnt;
    write_words(8'h30, 8);
    tick(6);
    n_total++; if (last_run !== 8) $display("FAIL b2b_consecutive: got %0d expected 8", last_run); else n_pass++;
    n_total++; if (rd_cnt - r0 !== 8) $display("FAIL b2b_reads: got %0d expected 8", rd_cnt - r0); else n_pass++;
    n_total++; if (acc_n - a0 !== 2) $display("FAIL b2b_words: got %0d expected 2", acc_n - a0); else n_pass++;
    n_total++; if (acc_data[a0] !== 32'h33323130) $display("FAIL b2b_word0: got %h expected 33323130", acc_data[a0]); else n_pass++;
    n_total++; if (acc_data[a0+1] !== 32'h37363534) $display("FAIL b2b_word1: got %h expected 37363534", acc_data[a0+1]); else n_pass++;
    n_total++; if (acc_cyc[a0+1] - acc_cyc[a0] !== 4) $display("FAIL b2b_spacing: got %0d expected 4", acc_cyc[a0+1] - acc_cyc[a0]); else n_pass++;
    n_total++; if (valid_cnt - v0 !== 2) $display("FAIL b2b_valid_cycles: got %0d expected 2", valid_cnt - v0); else n_pass++;
    n_total++; if (rd_empty_cnt !== 0) $display("FAIL rd_while_empty: got %0d expected 0", rd_empty_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_group;
    int a0;
    ready = 1'b1;
    write_words(8'h11, 2);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", valid); else n_pass++;
    n_total++; if (data !== 32'h0) $display("FAIL rstmid_data: got %h expected 00000000", data); else n_pass++;
    n_total++; if (keep !== 4'h0) $display("FAIL rstmid_keep: got %h expected 0", keep); else n_pass++;
    n_total++; if (rd_en !== 1'b0) $display("FAIL rstmid_rd_en: got %b expected 0", rd_en); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    a0 = acc_n;
    write_words(8'h21, 4);
    tick(6);
    n_total++; if (acc_n - a0 !== 1) $display("FAIL rstmid_words: got %0d expected 1", acc_n - a0); else n_pass++;
    n_total++; if (acc_data[a0] !== 32'h24232221) $display("FAIL rstmid_data_after: got %h expected 24232221", acc_data[a0]); else n_pass++;
    n_total++; if (acc_keep[a0] !== 4'hF) $display("FAIL rstmid_keep_after: got %h expected f", acc_keep[a0]); else n_pass++;
  endtask

`ifdef FIFO_RD_PACKER_FLUSH_EN
  task automatic test_flush_partial;
    int a0, f0;
    ready = 1'b1;
    write_words(8'hAA, 1);
    write_words(8'hBB, 1);
    tick(3);
    a0 = acc_n; f0 = fd_cnt;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(6);
    n_total++; if (acc_n - a0 !== 1) $display("FAIL flush_words: got %0d expected 1", acc_n - a0); else n_pass++;
    n_total++; if (acc_data[a0] !== 32'h0000BBAA) $display("FAIL flush_data: got %h expected 0000bbaa", acc_data[a0]); else n_pass++;
    n_total++; if (acc_keep[a0] !== 4'b0011) $display("FAIL flush_keep: got %b expected 0011", acc_keep[a0]); else n_pass++;
    n_total++; if (acc_fd[a0] !== 1'b1) $display("FAIL flush_done_with_valid: got %b expected 1", acc_fd[a0]); else n_pass++;
    n_total++; if (fd_cnt - f0 !== 1) $display("FAIL flush_done_count: got %0d expected 1", fd_cnt - f0); else n_pass++;
    n_total++; if (fd_cyc - flush_cyc !== 3) $display("FAIL flush_latency: got %0d expected 3", fd_cyc - flush_cyc); else n_pass++;
    a0 = acc_n;
    write_words(8'h01, 4);
    tick(6);
    n_total++; if (acc_data[a0] !== 32'h04030201) $display("FAIL flush_after_data: got %h expected 04030201", acc_data[a0]); else n_pass++;
    n_total++; if (acc_keep[a0] !== 4'hF) $display("FAIL flush_after_keep: got %h expected f", acc_keep[a0]); else n_pass++;
  endtask

  task automatic test_flush_empty;
    int a0, f0;
    a0 = acc_n; f0 = fd_cnt;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(5);
    n_total++; if (acc_n - a0 !== 0) $display("FAIL flush_empty_words: got %0d expected 0", acc_n - a0); else n_pass++;
    n_total++; if (fd_cnt - f0 !== 1) $display("FAIL flush_empty_done: got %0d expected 1", fd_cnt - f0); else n_pass++;
    n_total++; if (fd_cyc - flush_cyc !== 2) $display("FAIL flush_empty_latency: got %0d expected 2", fd_cyc - flush_cyc); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL flush_empty_valid: got %b expected 0", valid); else n_pass++;
  endtask
`else
  task automatic test_flush_ignored;
    int a0, f0;
    ready = 1'b1;
    a0 = acc_n; f0 = fd_cnt;
    write_words(8'h41, 2);
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(3);
    n_total++; if (acc_n - a0 !== 0) $display("FAIL noflush_partial: got %0d expected 0", acc_n - a0); else n_pass++;
    write_words(8'h43, 2);
    tick(6);
    n_total++; if (acc_n - a0 !== 1) $display("FAIL noflush_words: got %0d expected 1", acc_n - a0); else n_pass++;
    n_total++; if (acc_data[a0] !== 32'h44434241) $display("FAIL noflush_data: got %h expected 44434241", acc_data[a0]); else n_pass++;
    n_total++; if (fd_cnt - f0 !== 0) $display("FAIL noflush_done: got %0d expected 0", fd_cnt - f0); else n_pass++;
  endtask
`endif

  initial begin
    wr = 1'b0; wd = '0; ready = 1'b0; flush = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_group();
`ifdef FIFO_RD_PACKER_FLUSH_EN
    test_flush_partial();
    test_flush_empty();
`else
    test_flush_ignored();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
